// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the MEM-stage SRAM controller
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [31:0] DATA_MEM_BASE     = 32'd1024;
  localparam int          DEFAULT_SRAM_WAIT = 5;

endpackage

// File: rtl/sram_wait_counter.sv
// rtl/sram_wait_counter.sv - SRAM access wait counter with clear, enable and terminal count
module sram_wait_counter
  import mem_pkg::*;
#(
  parameter int WAIT = DEFAULT_SRAM_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= 4'd0;
    end else if (enable) begin
      count <= count + 4'd1;
    end
  end

  // tc marks the last of WAIT enabled cycles counted from a clear
  assign tc = (count == 4'(WAIT - 1));

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// rtl/mem_stage_sram_ctrl.sv - MEM-stage controller driving a multi-cycle SRAM and stalling the pipeline
module mem_stage_sram_ctrl
  import mem_pkg::*;
#(
  parameter int SRAM_WAIT = DEFAULT_SRAM_WAIT,
  parameter int ADDR_W    = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [31:0]       ALU_result,
  input  logic [31:0]       Val_Rm,
  output logic [31:0]       Mem_read_value,
  output logic              ready,
  output logic              freeze,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic              sram_we_n,
  input  logic [31:0]       sram_rdata
);

  state_t state;
  logic   req;
  logic   is_load;
  logic   wait_tc;

  assign req     = MEM_R_EN | MEM_W_EN;
  // a simultaneous read and write request is treated as a store
  assign is_load = MEM_R_EN & ~MEM_W_EN;

  sram_wait_counter #(
    .WAIT(SRAM_WAIT)
  ) u_wait (
    .clk   (clk),
    .rst   (rst),
    .clear ((state == IDLE) & req),
    .enable(state == ACCESS),
    .tc    (wait_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      Mem_read_value <= 32'd0;
    end else begin
      case (state)
        IDLE:    if (req) state <= ACCESS;
        ACCESS: begin
          if (wait_tc) begin
            state <= DONE;
            if (is_load) Mem_read_value <= sram_rdata;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready      = (state == DONE);
  assign freeze     = req & ~ready;
  assign sram_addr  = ADDR_W'((ALU_result - DATA_MEM_BASE) >> 2);
  assign sram_wdata = Val_Rm;
  assign sram_we_n  = ~((state == ACCESS) & MEM_W_EN);

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb/tb_mem_stage_sram_ctrl.sv - directed self-checking bench for mem_stage_sram_ctrl
module tb_mem_stage_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r, w;
  logic [31:0] alu, val, rd;
  logic [31:0] mrv, wdata;
  logic        ready, freeze, we_n;
  logic [16:0] addr;

  logic        r1, w1;
  logic [31:0] alu1, val1, rd1;
  logic [31:0] mrv1, wdata1;
  logic        ready1, freeze1, we_n1;
  logic [16:0] addr1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage_sram_ctrl u_dut (
    .clk(clk), .rst(rst), .MEM_R_EN(r), .MEM_W_EN(w), .ALU_result(alu), .Val_Rm(val),
    .Mem_read_value(mrv), .ready(ready), .freeze(freeze), .sram_addr(addr),
    .sram_wdata(wdata), .sram_we_n(we_n), .sram_rdata(rd)
  );

  mem_stage_sram_ctrl #(.SRAM_WAIT(1), .ADDR_W(17)) u_dut1 (
    .clk(clk), .rst(rst), .MEM_R_EN(r1), .MEM_W_EN(w1), .ALU_result(alu1), .Val_Rm(val1),
    .Mem_read_value(mrv1), .ready(ready1), .freeze(freeze1), .sram_addr(addr1),
    .sram_wdata(wdata1), .sram_we_n(we_n1), .sram_rdata(rd1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Runs one isolated request for 7 cycles starting just after a rising edge.
  task automatic access(input logic rr, input logic ww, input logic [31:0] a, input logic [31:0] v,
                        input logic [31:0] d, output int fz, output int wel, output int rdy_at,
                        output int rdy_n);
    r = rr; w = ww; alu = a; val = v; rd = d;
    fz = 0; wel = 0; rdy_at = -1; rdy_n = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (freeze) fz++;
      if (!we_n) wel++;
      if (ready) begin
        rdy_n++;
        rdy_at = c;
      end
      cyc();
    end
    r = 1'b0;
    w = 1'b0;
  endtask

  initial begin
    int fz, wel, rdy_at, rdy_n, first_rdy, last_rdy, acc_c, hits;
    r = 0; w = 0; alu = 0; val = 0; rd = 0;
    r1 = 0; w1 = 0; alu1 = 32'd1024; val1 = 0; rd1 = 0;
    rst = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_ready", ready, 1'b0);
    chk("rst_freeze", freeze, 1'b0);
    chk("rst_mrv", mrv, 32'h0);
    chk("rst_we_n", we_n, 1'b1);
    cyc();
    rst = 1'b0;

    access(1'b1, 1'b0, 32'd1028, 32'h0, 32'hDEADBEEF, fz, wel, rdy_at, rdy_n);
    chk("load_freeze_cycles", fz, 6);
    chk("load_ready_at", rdy_at, 6);
    chk("load_ready_pulses", rdy_n, 1);
    chk("load_we_low", wel, 0);
    chk("load_addr", addr, 17'd1);
    chk("load_mrv", mrv, 32'hDEADBEEF);

    access(1'b0, 1'b1, 32'd1032, 32'h12345678, 32'hCAFEF00D, fz, wel, rdy_at, rdy_n);
    chk("store_we_low", wel, 5);
    chk("store_freeze_cycles", fz, 6);
    chk("store_ready_at", rdy_at, 6);
    chk("store_addr", addr, 17'd2);
    chk("store_wdata", wdata, 32'h12345678);
    chk("store_mrv_kept", mrv, 32'hDEADBEEF);

    access(1'b1, 1'b1, 32'd1036, 32'h0BADF00D, 32'h5A5A5A5A, fz, wel, rdy_at, rdy_n);
    chk("both_we_low", wel, 5);
    chk("both_addr", addr, 17'd3);
    chk("both_mrv_kept", mrv, 32'hDEADBEEF);

    // load then store with the store presented in the IDLE cycle right after DONE
    r = 1'b1; w = 1'b0; alu = 32'd1028; rd = 32'h11112222;
    rdy_n = 0; first_rdy = -1; last_rdy = -1; acc_c = -1;
    for (int c = 0; c < 16; c++) begin
      if (c == 7) begin
        r = 1'b0; w = 1'b1; alu = 32'd1032; val = 32'h77;
      end
      if (c == 14) w = 1'b0;
      @(negedge clk);
      if (ready) begin
        rdy_n++;
        if (first_rdy < 0) first_rdy = c;
        last_rdy = c;
      end
      if (!we_n && acc_c < 0) acc_c = c;
      cyc();
    end
    chk("b2b_ready_pulses", rdy_n, 2);
    chk("b2b_first_ready", first_rdy, 6);
    chk("b2b_second_access", acc_c, 8);
    chk("b2b_second_ready", last_rdy, 13);
    chk("b2b_mrv", mrv, 32'h11112222);

    // reset during the third ACCESS cycle of a store
    w = 1'b1; alu = 32'd1032; val = 32'h55;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      cyc();
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_we_before", we_n, 1'b0);
    cyc();
    @(negedge clk);
    chk("rst_mid_we_n", we_n, 1'b1);
    chk("rst_mid_mrv", mrv, 32'h0);
    chk("rst_mid_ready", ready, 1'b0);
    cyc();
    rst = 1'b0; w = 1'b0;
    rdy_n = 0; hits = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ready) rdy_n++;
      if (freeze1 || ready1) hits++;
      cyc();
    end
    chk("rst_mid_no_ready", rdy_n, 0);
    chk("w1_idle_quiet", hits, 0);

    // SRAM_WAIT = 1 instance: address wrap and short latency
    r1 = 1'b1; alu1 = 32'd0; rd1 = 32'h600DCAFE;
    @(negedge clk);
    chk("w1_addr_wrap", addr1, 17'h1FF00);
    chk("w1_freeze_c0", freeze1, 1'b1);
    cyc();
    @(negedge clk);
    chk("w1_freeze_c1", freeze1, 1'b1);
    chk("w1_ready_c1", ready1, 1'b0);
    cyc();
    @(negedge clk);
    chk("w1_ready_c2", ready1, 1'b1);
    chk("w1_freeze_c2", freeze1, 1'b0);
    chk("w1_mrv", mrv1, 32'h600DCAFE);
    cyc();
    r1 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
